// File: rtl/pipe_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA, plus ROL/ROR when PIPE_SHIFT_ROTATE_EN is defined)
// with a valid/ready handshake, destination-tag pass-through and flush.
module pipe_shift_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       operand,
    input  logic [$clog2(WIDTH):0] sh_amt,
    input  logic [$clog2(WIDTH):0] v_sh_amt,
    input  logic                   use_var,
    input  logic [2:0]             op,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       shift_out,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   illegal_op
);

    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam int unsigned AMT_W = LOG_W + 1;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
        logic             illegal;
        logic             sign;
        logic [AMT_W-1:0] amt;
        logic [LOG_W-1:0] rot;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           in_stage;
    stage_t           src [PIPE_STAGES];
    stage_t           nxt [PIPE_STAGES];
    stage_t           q   [PIPE_STAGES];
    logic [AMT_W-1:0] amt;
    logic             in_illegal;
    logic             advance;

    // Rotate level j (by 2**j) is performed in this pipeline stage.
    function automatic int unsigned level_stage(input int unsigned j);
        return (j * PIPE_STAGES) / LOG_W;
    endfunction

    function automatic logic [WIDTH-1:0] rotl_pow2(input logic [WIDTH-1:0] d,
                                                   input int unsigned j);
        return (d << (1 << j)) | (d >> (WIDTH - (1 << j)));
    endfunction

    // Every op is a left rotate; shifts then mask off the wrapped bits and apply fill.
    function automatic logic [WIDTH-1:0] finalize(input stage_t st);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] hi_mask;
        logic [WIDTH-1:0] lo_mask;
        logic [WIDTH-1:0] res;
        logic             big;
        ones    = '1;
        big     = st.amt[LOG_W];
        hi_mask = ones << st.amt[LOG_W-1:0];
        lo_mask = ones >> st.amt[LOG_W-1:0];
        res     = '0;
        case (st.op)
            OP_SLL: res = big ? '0 : (st.data & hi_mask);
            OP_SRL: res = big ? '0 : (st.data & lo_mask);
            OP_SRA: res = big ? {WIDTH{st.sign}}
                              : ((st.data & lo_mask) | ({WIDTH{st.sign}} & ~lo_mask));
`ifdef PIPE_SHIFT_ROTATE_EN
            OP_ROL, OP_ROR: res = st.data;
`endif
            default: res = '0;
        endcase
        if (st.illegal) begin
            res = '0;
        end
        return res;
    endfunction

`ifdef PIPE_SHIFT_ROTATE_EN
    assign in_illegal = (op > OP_ROR);
`else
    assign in_illegal = (op > OP_SRA);
`endif

    assign amt = use_var ? v_sh_amt : sh_amt;

    always_comb begin
        in_stage         = '0;
        in_stage.valid   = in_valid;
        in_stage.tag     = in_tag;
        in_stage.op      = op;
        in_stage.illegal = in_illegal;
        in_stage.sign    = operand[WIDTH-1];
        in_stage.amt     = amt;
        in_stage.data    = operand;
        // Right shifts/rotates become a left rotate by (WIDTH - amt) mod WIDTH.
        if (op == OP_SRL || op == OP_SRA || op == OP_ROR) begin
            in_stage.rot = (~amt[LOG_W-1:0]) + 1'b1;
        end else begin
            in_stage.rot = amt[LOG_W-1:0];
        end
    end

    assign src[0] = in_stage;
    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_src
        assign src[s] = q[s-1];
    end

    always_comb begin
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            nxt[s] = src[s];
            for (int unsigned j = 0; j < LOG_W; j++) begin
                if (level_stage(j) == s && src[s].rot[j]) begin
                    nxt[s].data = rotl_pow2(nxt[s].data, j);
                end
            end
            if (s == PIPE_STAGES - 1) begin
                nxt[s].data = finalize(nxt[s]);
            end
        end
    end

    assign advance  = !q[PIPE_STAGES-1].valid || out_ready;
    assign in_ready = advance;

    // Flush drops valid bits only; payload is don't-care once invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                q[s] <= '0;
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                q[s].valid <= 1'b0;
            end
        end else if (advance) begin
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                q[s] <= nxt[s];
            end
        end
    end

    assign out_valid  = q[PIPE_STAGES-1].valid;
    assign shift_out  = q[PIPE_STAGES-1].data;
    assign out_tag    = q[PIPE_STAGES-1].tag;
    assign illegal_op = q[PIPE_STAGES-1].illegal;

endmodule
